// File: rtl/kalman_step_scheduler.sv
// Sequencer for one Kalman filter iteration: prediction, gain, covariance update, state update.
// Adds a per-phase watchdog, a one-deep sample buffer, overrun and iteration counters.
module kalman_step_scheduler #(
   parameter int TO_W    = 16,
   parameter int TIMEOUT = 4096,
   parameter int STEP_W  = 16,
   parameter int OVR_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_en,
   input  logic              enable,
   input  logic              sample_valid,
   input  logic              err_clear,
   output logic              start_prediction,
   output logic              start_k_g,
   input  logic              end_prediction,
   input  logic              end_k_g,
   input  logic              end_update,
   output logic              start_x_update,
   input  logic              x_update_done,
   output logic              busy,
   output logic              step_done,
   output logic [2:0]        phase,
   output logic              error,
   output logic [2:0]        err_phase,
   output logic [STEP_W-1:0] step_count,
   output logic [OVR_W-1:0]  overrun_cnt,
   output logic              pending
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRED = 3'd1,
      S_KG   = 3'd2,
      S_UPD  = 3'd3,
      S_XUPD = 3'd4,
      S_DONE = 3'd5,
      S_ERR  = 3'd7
   } state_t;

   localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT - 1);

   state_t            state_q, state_d, next_ph;
   logic              first_q, first_d;
   logic [TO_W-1:0]   wd_q, wd_d;
   logic              pending_q, pending_d;
   logic [OVR_W-1:0]  ovr_q, ovr_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [2:0]        err_phase_q, err_phase_d;
   logic              start_pred_q, start_pred_d;
   logic              start_kg_q, start_kg_d;
   logic              start_xupd_q, start_xupd_d;
   logic              step_done_q, step_done_d;
   logic              busy_q, busy_d;
   logic              error_q, error_d;
   logic              launch, done_in;

   always_comb begin
      state_d     = state_q;
      first_d     = 1'b0;
      wd_d        = wd_q;
      pending_d   = pending_q;
      ovr_d       = ovr_q;
      step_d      = step_q;
      err_phase_d = err_phase_q;
      next_ph     = state_q;
      done_in     = 1'b0;
      launch      = ((state_q == S_IDLE) || (state_q == S_DONE)) && enable &&
                    (sample_valid || pending_q);

      case (state_q)
         S_PRED:  begin done_in = end_prediction; next_ph = S_KG;   end
         S_KG:    begin done_in = end_k_g;        next_ph = S_UPD;  end
         S_UPD:   begin done_in = end_update;     next_ph = S_XUPD; end
         S_XUPD:  begin done_in = x_update_done;  next_ph = S_DONE; end
         default: begin done_in = 1'b0;           next_ph = state_q; end
      endcase

      case (state_q)
         S_IDLE: if (launch) state_d = S_PRED;
         // first_q masks completion flags still high from the previous step
         S_PRED, S_KG, S_UPD, S_XUPD: begin
            if (!first_q && done_in) begin
               state_d = next_ph;
            end else if (wd_q == TO_LIM) begin
               state_d     = S_ERR;
               err_phase_d = state_q;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         S_DONE: state_d = launch ? S_PRED : S_IDLE;
         S_ERR: begin
            if (err_clear) begin
               state_d     = S_IDLE;
               pending_d   = 1'b0;
               err_phase_d = 3'd0;
               wd_d        = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q) begin
         wd_d    = '0;
         first_d = (state_d == S_PRED) || (state_d == S_KG) ||
                   (state_d == S_UPD)  || (state_d == S_XUPD);
      end

      if ((state_d == S_DONE) && (state_q != S_DONE)) step_d = step_q + 1'b1;

      // On launch with a new sample and a pending one, the new sample takes the buffer slot.
      if (sample_valid) begin
         if (launch) begin
            pending_d = pending_q;
         end else if (state_q == S_ERR) begin
            if (ovr_q != '1) ovr_d = ovr_q + 1'b1;
         end else if (state_q != S_IDLE) begin
            if (!pending_q)          pending_d = 1'b1;
            else if (ovr_q != '1)    ovr_d = ovr_q + 1'b1;
         end
      end else if (launch) begin
         pending_d = 1'b0;
      end

      start_pred_d = (state_d == S_PRED) && (state_q != S_PRED);
      start_kg_d   = (state_d == S_KG)   && (state_q != S_KG);
      start_xupd_d = (state_d == S_XUPD) && (state_q != S_XUPD);
      step_done_d  = (state_d == S_DONE);
      busy_d       = (state_d != S_IDLE) && (state_d != S_ERR);
      error_d      = (state_d == S_ERR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         first_q      <= 1'b0;
         wd_q         <= '0;
         pending_q    <= 1'b0;
         ovr_q        <= '0;
         step_q       <= '0;
         err_phase_q  <= 3'd0;
         start_pred_q <= 1'b0;
         start_kg_q   <= 1'b0;
         start_xupd_q <= 1'b0;
         step_done_q  <= 1'b0;
         busy_q       <= 1'b0;
         error_q      <= 1'b0;
      end else if (clk_en) begin
         state_q      <= state_d;
         first_q      <= first_d;
         wd_q         <= wd_d;
         pending_q    <= pending_d;
         ovr_q        <= ovr_d;
         step_q       <= step_d;
         err_phase_q  <= err_phase_d;
         start_pred_q <= start_pred_d;
         start_kg_q   <= start_kg_d;
         start_xupd_q <= start_xupd_d;
         step_done_q  <= step_done_d;
         busy_q       <= busy_d;
         error_q      <= error_d;
      end
   end

   assign start_prediction = start_pred_q;
   assign start_k_g        = start_kg_q;
   assign start_x_update   = start_xupd_q;
   assign busy             = busy_q;
   assign step_done        = step_done_q;
   assign phase            = state_q;
   assign error            = error_q;
   assign err_phase        = err_phase_q;
   assign step_count       = step_q;
   assign overrun_cnt      = ovr_q;
   assign pending          = pending_q;

endmodule

// File: tb/tb_kalman_step_scheduler.sv
// Bench for kalman_step_scheduler: directed steps with a stub generator, scoreboard on phase and step events.
// A second instance with a short timeout exercises the watchdog.
module tb_kalman_step_scheduler;

   localparam int STEP_W = 16;
   localparam int OVR_W  = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic gate_mode = 1'b0;
   logic gate_ph = 1'b1;
   logic clk_en;
   logic enable = 1'b0, sample_valid = 1'b0, err_clear = 1'b0;
   logic end_prediction = 1'b0, end_k_g = 1'b0, end_update = 1'b0, x_update_done = 1'b0;
   logic w_end_k_g = 1'b0;

   logic start_prediction, start_k_g, start_x_update, busy, step_done, error, pending;
   logic [2:0] phase, err_phase;
   logic [STEP_W-1:0] step_count;
   logic [OVR_W-1:0] overrun_cnt;

   logic w_start_prediction, w_start_k_g, w_start_x_update, w_busy, w_step_done, w_error, w_pending;
   logic [2:0] w_phase, w_err_phase;
   logic [STEP_W-1:0] w_step_count;
   logic [OVR_W-1:0] w_overrun_cnt;

   int pass_cnt = 0;
   int total_cnt = 0;
   logic [2:0] exp_phase_q[$];
   logic [STEP_W-1:0] exp_step_q[$];
   logic [2:0] last_phase = 3'd0;
   logic prev_done = 1'b0;
   int st_cnt[3] = '{0, 0, 0};

   // clock / reset / enable generation
   always #5 clk = ~clk;
   always @(negedge clk) gate_ph <= ~gate_ph;
   assign clk_en = gate_mode ? gate_ph : 1'b1;

   kalman_step_scheduler #(.TIMEOUT(64)) u_dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .enable(enable),
      .sample_valid(sample_valid), .err_clear(err_clear),
      .start_prediction(start_prediction), .start_k_g(start_k_g),
      .end_prediction(end_prediction), .end_k_g(end_k_g), .end_update(end_update),
      .start_x_update(start_x_update), .x_update_done(x_update_done),
      .busy(busy), .step_done(step_done), .phase(phase), .error(error),
      .err_phase(err_phase), .step_count(step_count), .overrun_cnt(overrun_cnt),
      .pending(pending)
   );

   kalman_step_scheduler #(.TIMEOUT(16)) u_wd (
      .clk(clk), .reset(reset), .clk_en(clk_en), .enable(enable),
      .sample_valid(sample_valid), .err_clear(err_clear),
      .start_prediction(w_start_prediction), .start_k_g(w_start_k_g),
      .end_prediction(end_prediction), .end_k_g(w_end_k_g), .end_update(end_update),
      .start_x_update(w_start_x_update), .x_update_done(x_update_done),
      .busy(w_busy), .step_done(w_step_done), .phase(w_phase), .error(w_error),
      .err_phase(w_err_phase), .step_count(w_step_count), .overrun_cnt(w_overrun_cnt),
      .pending(w_pending)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // scoreboard monitor: phase sequence, step completions, start pulse widths
   always @(negedge clk) begin
      logic [2:0] st;
      if (phase !== last_phase) begin
         if (exp_phase_q.size() == 0) begin
            total_cnt++;
            $display("FAIL phase_unexpected: got %0d with no expected entry", phase);
         end else begin
            chk("phase_seq", phase, exp_phase_q.pop_front());
         end
         last_phase = phase;
      end
      if (step_done && !prev_done) begin
         if (exp_step_q.size() == 0) begin
            total_cnt++;
            $display("FAIL step_unexpected: step_count %0d with no expected entry", step_count);
         end else begin
            chk("step_count_at_done", step_count, exp_step_q.pop_front());
         end
      end
      prev_done = step_done;
      st = {start_x_update, start_k_g, start_prediction};
      for (int i = 0; i < 3; i++) begin
         if (st[i]) begin
            st_cnt[i]++;
         end else if (st_cnt[i] != 0) begin
            chk("start_width", st_cnt[i], gate_mode ? 2 : 1);
            st_cnt[i] = 0;
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic en_tick();
      logic e;
      do begin
         @(posedge clk);
         e = clk_en;
         #1;
      end while (!e);
   endtask

   task automatic pulse(input int sel);
      case (sel)
         0: end_prediction = 1'b1;
         1: end_k_g = 1'b1;
         2: end_update = 1'b1;
         3: x_update_done = 1'b1;
         4: sample_valid = 1'b1;
         default: err_clear = 1'b1;
      endcase
      en_tick();
      case (sel)
         0: end_prediction = 1'b0;
         1: end_k_g = 1'b0;
         2: end_update = 1'b0;
         3: x_update_done = 1'b0;
         4: sample_valid = 1'b0;
         default: err_clear = 1'b0;
      endcase
   endtask

   function automatic logic out_sel(input int sel);
      case (sel)
         0: return start_prediction;
         1: return start_k_g;
         default: return start_x_update;
      endcase
   endfunction

   task automatic wait_start(input int sel, input string name);
      int n = 0;
      while (!out_sel(sel) && n < 400) begin
         tick();
         n++;
      end
      chk(name, out_sel(sel), 1);
   endtask

   task automatic run_step(input int lp, input int lk, input int lu, input int lx,
                           input bit hold_upd, input int extra);
      wait_start(0, "wait_start_prediction");
      for (int i = 0; i < extra; i++) pulse(4);
      repeat (lp) en_tick();
      pulse(0);
      wait_start(1, "wait_start_k_g");
      repeat (lk) en_tick();
      pulse(1);
      if (hold_upd) begin
         chk("stale_upd_entry", phase, 3);
         en_tick();
         chk("stale_upd_masked", phase, 3);
         en_tick();
         chk("stale_upd_exit", phase, 4);
      end else begin
         repeat (lu) en_tick();
         pulse(2);
      end
      wait_start(2, "wait_start_x_update");
      repeat (lx) en_tick();
      pulse(3);
   endtask

   task automatic reset_all();
      reset = 1'b1;
      sample_valid = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic push_phases(input int n, input logic [2:0] seq[16]);
      for (int i = 0; i < n; i++) exp_phase_q.push_back(seq[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [2:0] nom[16];
      logic [2:0] two[16];
      nom = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
      two = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

      // reset state
      repeat (2) tick();
      chk("rst_phase", phase, 0);
      chk("rst_busy", busy, 0);
      chk("rst_start_prediction", start_prediction, 0);
      reset = 1'b0;
      enable = 1'b1;
      tick();
      chk("rst_step_count", step_count, 0);
      chk("rst_overrun", overrun_cnt, 0);
      chk("rst_pending", pending, 0);
      chk("rst_error", error, 0);
      chk("rst_err_phase", err_phase, 0);
      chk("rst_step_done", step_done, 0);
      repeat (2) tick();

      // nominal step
      push_phases(6, nom);
      exp_step_q.push_back(16'd1);
      pulse(4);
      chk("nom_start_prediction", start_prediction, 1);
      run_step(20, 30, 10, 8, 1'b0, 0);
      chk("nom_step_done", step_done, 1);
      chk("nom_done_phase", phase, 5);
      repeat (3) tick();
      chk("nom_step_count", step_count, 1);
      chk("nom_idle_busy", busy, 0);

      // buffering and overrun: three extra samples during PRED
      reset_all();
      push_phases(11, two);
      exp_step_q.push_back(16'd1);
      exp_step_q.push_back(16'd2);
      pulse(4);
      run_step(20, 30, 10, 8, 1'b0, 3);
      chk("buf_pending", pending, 1);
      chk("buf_overrun", overrun_cnt, 2);
      run_step(6, 6, 6, 6, 1'b0, 0);
      repeat (3) tick();
      chk("buf_step_count", step_count, 2);
      chk("buf_pending_after", pending, 0);

      // sample with enable low in IDLE is ignored
      enable = 1'b0;
      pulse(4);
      tick();
      chk("dis_phase", phase, 0);
      chk("dis_overrun", overrun_cnt, 2);
      chk("dis_pending", pending, 0);
      enable = 1'b1;

      // clk_en gating: long KG wait only fits if the watchdog counts enabled cycles
      reset_all();
      gate_mode = 1'b1;
      push_phases(6, nom);
      exp_step_q.push_back(16'd1);
      pulse(4);
      run_step(20, 40, 10, 8, 1'b0, 0);
      repeat (4) tick();
      gate_mode = 1'b0;
      tick();
      chk("gate_step_count", step_count, 1);
      chk("gate_error", error, 0);

      // stale end_update level held through the whole step
      reset_all();
      end_update = 1'b1;
      push_phases(6, nom);
      exp_step_q.push_back(16'd1);
      pulse(4);
      run_step(5, 5, 0, 4, 1'b1, 0);
      repeat (3) tick();
      chk("stale_step_count", step_count, 1);
      end_update = 1'b0;

      // watchdog on the short-timeout instance, then async reset of the main one in KG
      reset_all();
      exp_phase_q.push_back(3'd1);
      exp_phase_q.push_back(3'd2);
      pulse(4);
      wait_start(0, "wd_wait_start_prediction");
      pulse(4);
      pulse(4);
      repeat (3) en_tick();
      pulse(0);
      chk("wd_start_k_g", w_start_k_g, 1);
      repeat (15) en_tick();
      chk("wd_still_kg", w_phase, 2);
      en_tick();
      chk("wd_err_phase_state", w_phase, 7);
      chk("wd_error", w_error, 1);
      chk("wd_err_phase", w_err_phase, 2);
      chk("wd_busy", w_busy, 0);
      pulse(5);
      chk("wd_clear_phase", w_phase, 0);
      chk("wd_clear_error", w_error, 0);
      chk("main_kg_overrun", overrun_cnt, 1);
      chk("main_kg_pending", pending, 1);

      exp_phase_q.push_back(3'd0);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("arst_phase", phase, 0);
      chk("arst_busy", busy, 0);
      chk("arst_overrun", overrun_cnt, 0);
      chk("arst_pending", pending, 0);
      chk("arst_start_k_g", start_k_g, 0);
      tick();
      reset = 1'b0;
      tick();
      push_phases(6, nom);
      exp_step_q.push_back(16'd1);
      pulse(4);
      chk("arst_restart_pred", phase, 1);
      run_step(4, 4, 4, 4, 1'b0, 0);
      repeat (3) tick();
      chk("arst_step_count", step_count, 1);

      chk("phase_queue_empty", exp_phase_q.size(), 0);
      chk("step_queue_empty", exp_step_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/kalman_step_scheduler.md
Name: kalman_step_scheduler

Overview:
- Top-level sequencer for one Kalman filter iteration.
- On each new measurement it starts covariance prediction, then Kalman gain, waits for the covariance update, then starts the state-estimate update.
- Drives the start inputs of covariance_matrix_generator and of the state estimator; consumes their completion flags.
- Provides a per-phase watchdog, one-deep sample buffering, overrun counting and an iteration counter.

Parameters:
TO_W, 16, width of the per-phase watchdog counter
TIMEOUT, 4096, enabled cycles allowed per wait phase before error (1..2^TO_W-1)
STEP_W, 16, width of the iteration counter
OVR_W, 8, width of the saturating overrun counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clk_en  in  1  clock enable; all state/registers advance only when 1
enable  in  1  1 = accept samples; 0 = finish current step, then idle
sample_valid  in  1  one-cycle (enabled) strobe: new measurement available
err_clear  in  1  leave ERR state (enabled cycle)
start_prediction  out  1  to generator Start_Prediction
start_k_g  out  1  to generator Start_K_G
end_prediction  in  1  generator end_Prediction (level)
end_k_g  in  1  generator end_K_G (pulse)
end_update  in  1  generator end_Update (level)
start_x_update  out  1  start state-estimate update
x_update_done  in  1  state estimator completion (pulse or level)
busy  out  1  1 in any state except IDLE and ERR
step_done  out  1  one enabled cycle at end of each successful step
phase  out  3  current state encoding
error  out  1  1 while in ERR
err_phase  out  3  phase in which the watchdog expired
step_count  out  STEP_W  completed steps, wraps
overrun_cnt  out  OVR_W  dropped samples, saturating
pending  out  1  one sample buffered

Behaviour:
- Reset (async):
  - state IDLE; all outputs 0; counters 0; pending 0.
  - Reset mid-step aborts immediately; start pulses drop asynchronously.
- All registered outputs. clk_en=0 freezes every register, including the watchdog.
- States and phase encoding: IDLE=0, PRED=1, KG=2, UPD=3, XUPD=4, DONE=5, ERR=7.
- IDLE -> PRED when enable && (sample_valid || pending). Consumes pending if set; otherwise the new sample.
- Issue rule:
  - On the enabled edge entering PRED/KG/XUPD, the matching start_* goes 1 for exactly one enabled cycle.
  - Completion inputs are ignored during that issue cycle, which masks stale level flags.
- Phase transitions:
  - PRED -> KG when end_prediction=1.
  - KG -> UPD when end_k_g=1.
  - UPD -> XUPD when end_update=1.
  - XUPD -> DONE when x_update_done=1.
- DONE (1 enabled cycle):
  - step_done=1; step_count+1 (wraps to 0).
  - Then PRED if enable && (pending || sample_valid), else IDLE. Back-to-back steps have no IDLE gap.
- Watchdog:
  - Cleared on every phase entry; increments each enabled cycle spent waiting in PRED/KG/UPD/XUPD.
  - When it reaches TIMEOUT-1 with no completion -> ERR; err_phase = phase.
  - A completion in the same cycle as expiry wins: the normal transition is taken.
- ERR: no starts issued; samples arriving are dropped and counted as overrun. err_clear -> IDLE, clearing pending, err_phase and watchdog.
- Sample buffering:
  - sample_valid while busy (not in the DONE cycle that consumes it): if pending=0, set pending=1.
  - If pending=1, overrun_cnt+1, saturating at all-ones.
  - sample_valid in IDLE with enable=0 is ignored (not counted).
- enable falling mid-step: current step completes. pending is kept but not launched until enable=1.
- The generator's end_update remains high from the previous step; it is sampled only in UPD after the issue rule, so no false advance occurs.

Test Plan:
- Nominal:
  - Stimulus: reset, enable=1, clk_en=1, sample_valid at cycle 5; stub returns end_prediction after 20 cycles, end_k_g after 30, end_update after 10, x_update_done after 8.
  - Required: start_prediction pulse at cycle 6; phases 1->2->3->4->5->0; step_done once; step_count=1.
- Buffering/overrun:
  - Stimulus: three sample_valid strobes during PRED of step 1.
  - Required: pending=1, overrun_cnt=2; step 2 enters PRED directly from DONE; step_count=2.
- Watchdog:
  - Stimulus: TIMEOUT=16; end_k_g never asserted.
  - Required: in KG, ERR entered 16 enabled cycles after issue; error=1, err_phase=2, busy=0; err_clear -> phase 0, error=0.
- clk_en gating:
  - Stimulus: nominal run with clk_en toggling 1,0.
  - Required: each start pulse is high for exactly one enabled cycle (two clk cycles); watchdog counts only enabled cycles; same final step_count.
- Stale level:
  - Stimulus: end_update held 1 continuously.
  - Required: no advance out of PRED or KG on end_update; UPD exits on its second enabled cycle.
- Async reset mid-KG:
  - Stimulus: assert reset between clock edges.
  - Required: all outputs 0 immediately; overrun_cnt=0; next sample restarts at PRED.
